// File: rtl/uart_tx_frame_if.sv
// Producer-facing bundle for uart_tx_frame: enqueue handshake, queue status and serial line.
interface uart_tx_frame_if #(
    parameter int DATA_BITS  = 9,
    parameter int FIFO_DEPTH = 4
);
    logic                        send;
    logic [DATA_BITS-1:0]        data;
    logic                        ready;
    logic                        tx;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] count;

    modport master (output send, output data, input ready, input tx, input busy, input count);
    modport slave  (input send, input data, output ready, output tx, output busy, output count);
endinterface

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: circular input queue feeding a framing FSM with
// configurable width, parity and stop bits; frames stream back-to-back.
module uart_tx_frame #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 9,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_frame_if.slave bus
);
    localparam int BIT_CYCLES = CLK_HZ / BAUD_RATE;
    localparam int BC_W       = (BIT_CYCLES >= 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(BIT_CYCLES - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx_frame: CLK_HZ / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic                 push, pop, bit_end;

    always_comb begin
        push      = bus.send && (count_q != CNT_FULL);
        pop       = 1'b0;
        bit_end   = (bit_cnt_q == BC_LAST);
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // idx counts stop bits here; the last one chains straight into the next frame
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d   = mem_q[rd_ptr_q];
            par_d     = (PARITY == 1) ? ~^mem_q[rd_ptr_q] : ^mem_q[rd_ptr_q];
            idx_d     = '0;
            bit_cnt_d = '0;
        end
    end

    always_comb begin
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) mem_d[wr_ptr_q] = bus.data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Queue storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.ready = (count_q != CNT_FULL);
    assign bus.busy  = (state_q != S_IDLE) || (count_q != '0);
    assign bus.count = count_q;
    assign bus.tx    = tx_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover 8N1, even/odd parity and 7-bit/2-stop framing.
module tb_uart_tx_frame;
    localparam int BC = 10;

    logic clk;
    logic rst_a, rst_o;
    int   total = 0;
    int   bad   = 0;

    uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
    uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_b ();
    uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_c ();
    uart_tx_frame_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_d ();

    uart_tx_frame #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_a (.clock(clk), .reset(rst_a), .bus(if_a.slave));
    uart_tx_frame #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_b (.clock(clk), .reset(rst_o), .bus(if_b.slave));
    uart_tx_frame #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_c (.clock(clk), .reset(rst_o), .bus(if_c.slave));
    uart_tx_frame #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u_d (.clock(clk), .reset(rst_o), .bus(if_d.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return if_a.tx;
            1:       return if_b.tx;
            2:       return if_c.tx;
            default: return if_d.tx;
        endcase
    endfunction

    task automatic set_send(input int sel, input logic en, input logic [8:0] val);
        case (sel)
            0:       begin if_a.send = en; if_a.data = val[7:0]; end
            1:       begin if_b.send = en; if_b.data = val[7:0]; end
            2:       begin if_c.send = en; if_c.data = val[7:0]; end
            default: begin if_d.send = en; if_d.data = val[6:0]; end
        endcase
    endtask

    task automatic send_one(input int sel, input logic [8:0] val);
        set_send(sel, 1'b1, val);
        @(negedge clk);
        set_send(sel, 1'b0, 9'h0);
    endtask

    task automatic wait_start(input int sel, input int maxc, input string tag);
        int n = 0;
        while (get_tx(sel) !== 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(get_tx(sel)), 32'h0);
    endtask

    // Entered on the first sample of the start bit; returns on the sample after the last stop cycle.
    task automatic check_frame(input int sel, input string tag, input logic [8:0] d, input int dbits,
                               input int has_par, input logic par, input int stops,
                               input logic push_en, input logic [8:0] push_val);
        logic [15:0] fb;
        int          n = 0;
        fb = '1;
        fb[n] = 1'b0; n++;
        for (int i = 0; i < dbits; i++) begin fb[n] = d[i]; n++; end
        if (has_par != 0) begin fb[n] = par; n++; end
        for (int i = 0; i < stops; i++) begin fb[n] = 1'b1; n++; end
        for (int b = 0; b < n; b++) begin
            int nbad = 0;
            for (int c = 0; c < BC; c++) begin
                if (get_tx(sel) !== fb[b]) nbad++;
                if (push_en && b == 3 && c == 0) set_send(sel, 1'b1, push_val);
                if (push_en && b == 3 && c == 1) set_send(sel, 1'b0, 9'h0);
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d_badcycles", tag, b), 32'(nbad), 32'h0);
        end
    endtask

    function automatic logic [8:0] wv(input int i);
        return 9'((i * 37 + 11) & 8'hFF);
    endfunction

    initial begin
        rst_a = 1'b1;
        rst_o = 1'b1;
        for (int s = 0; s < 4; s++) set_send(s, 1'b0, 9'h0);
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(if_a.tx),    32'h1);
        chk("rst_ready", 32'(if_a.ready), 32'h1);
        chk("rst_busy",  32'(if_a.busy),  32'h0);
        chk("rst_count", 32'(if_a.count), 32'h0);
        rst_a = 1'b0;
        rst_o = 1'b0;
        @(negedge clk);

        // single 8N1 frame with start latency
        send_one(0, 9'h0A5);
        chk("lat_count_k",  32'(if_a.count), 32'h1);
        @(negedge clk);
        chk("lat_tx_k1",    32'(if_a.tx),    32'h1);
        chk("lat_busy_k1",  32'(if_a.busy),  32'h1);
        chk("lat_count_k1", 32'(if_a.count), 32'h0);
        @(negedge clk);
        chk("lat_tx_k2",    32'(if_a.tx),    32'h0);
        check_frame(0, "a5_8n1", 9'h0A5, 8, 0, 1'b0, 1, 1'b0, 9'h0);
        chk("a5_busy_end",  32'(if_a.busy),  32'h0);
        chk("a5_tx_end",    32'(if_a.tx),    32'h1);

        // parity
        send_one(1, 9'h0A5);
        wait_start(1, 5, "even_a5");
        check_frame(1, "even_a5", 9'h0A5, 8, 1, 1'b0, 1, 1'b0, 9'h0);
        send_one(2, 9'h0A5);
        wait_start(2, 5, "odd_a5");
        check_frame(2, "odd_a5", 9'h0A5, 8, 1, 1'b1, 1, 1'b0, 9'h0);
        send_one(1, 9'h007);
        wait_start(1, 5, "even_07");
        check_frame(1, "even_07", 9'h007, 8, 1, 1'b1, 1, 1'b0, 9'h0);

        // 7-bit, two stop bits, second frame follows the 20-clock stop immediately
        set_send(3, 1'b1, 9'h041);
        @(negedge clk);
        set_send(3, 1'b1, 9'h015);
        @(negedge clk);
        set_send(3, 1'b0, 9'h0);
        wait_start(3, 5, "d41");
        check_frame(3, "d41", 9'h041, 7, 0, 1'b0, 2, 1'b0, 9'h0);
        check_frame(3, "d15", 9'h015, 7, 0, 1'b0, 2, 1'b0, 9'h0);
        chk("d_busy_end", 32'(if_d.busy), 32'h0);

        // queue full: six sends, five accepted, five frames back-to-back
        fork
            begin
                for (int w = 0; w < 6; w++) begin
                    set_send(0, 1'b1, 9'(w));
                    @(negedge clk);
                    if (w == 4) begin
                        chk("full_ready", 32'(if_a.ready), 32'h0);
                        chk("full_count", 32'(if_a.count), 32'h4);
                    end
                end
                chk("full_reject_count", 32'(if_a.count), 32'h4);
                set_send(0, 1'b0, 9'h0);
            end
            begin
                wait_start(0, 10, "full_f0");
                for (int f = 0; f < 5; f++)
                    check_frame(0, $sformatf("full_f%0d", f), 9'(f), 8, 0, 1'b0, 1, 1'b0, 9'h0);
                chk("full_busy_end", 32'(if_a.busy), 32'h0);
                chk("full_tx_end",   32'(if_a.tx),   32'h1);
            end
        join

        // wrap-around: 12 words, one new word pushed during each frame
        set_send(0, 1'b1, wv(0));
        @(negedge clk);
        set_send(0, 1'b1, wv(1));
        @(negedge clk);
        set_send(0, 1'b0, 9'h0);
        wait_start(0, 5, "wrap");
        for (int i = 0; i < 12; i++) begin
            if (i < 11)
                chk($sformatf("wrap_cnt%0d_in_range", i),
                    32'((if_a.count >= 1) && (if_a.count <= 3)), 32'h1);
            check_frame(0, $sformatf("wrap_w%0d", i), wv(i), 8, 0, 1'b0, 1, (i + 2 < 12), wv(i + 2));
        end
        chk("wrap_busy_end", 32'(if_a.busy), 32'h0);

        // reset during data bit 3 with two words queued; send during reset is ignored
        set_send(0, 1'b1, 9'h0C3);
        @(negedge clk);
        set_send(0, 1'b1, 9'h05A);
        @(negedge clk);
        set_send(0, 1'b1, 9'h03C);
        @(negedge clk);
        set_send(0, 1'b0, 9'h0);
        wait_start(0, 5, "rst_mid");
        chk("rst_mid_queued", 32'(if_a.count), 32'h2);
        repeat (4 * BC + 5) @(negedge clk);
        chk("rst_mid_tx_before", 32'(if_a.tx), 32'h0);
        rst_a = 1'b1;
        set_send(0, 1'b1, 9'h077);
        @(negedge clk);
        rst_a = 1'b0;
        set_send(0, 1'b0, 9'h0);
        chk("rst_mid_tx",    32'(if_a.tx),    32'h1);
        chk("rst_mid_count", 32'(if_a.count), 32'h0);
        chk("rst_mid_busy",  32'(if_a.busy),  32'h0);
        chk("rst_mid_ready", 32'(if_a.ready), 32'h1);
        begin
            int nlow = 0;
            int nbusy = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (if_a.tx !== 1'b1) nlow++;
                if (if_a.busy !== 1'b0) nbusy++;
            end
            chk("rst_quiet_tx_low_cycles", 32'(nlow),  32'h0);
            chk("rst_quiet_busy_cycles",   32'(nbusy), 32'h0);
        end
        send_one(0, 9'h096);
        wait_start(0, 5, "post_rst");
        check_frame(0, "post_rst_96", 9'h096, 8, 0, 1'b0, 1, 1'b0, 9'h0);
        chk("post_rst_busy_end", 32'(if_a.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised, buffered UART transmitter that generalises the single-word TX path. It adds a configurable word width, optional odd/even parity, one or two stop bits, and an internal bit-period counter. A `FIFO_DEPTH`-entry input queue lets producers enqueue words while a frame is in flight. It sits between the controller's message/scheduler logic and the serial pin, and streams queued frames with no idle gap between them.

## Interface
- `CLK_HZ`, default 25_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate. `BIT_CYCLES = CLK_HZ / BAUD_RATE` (integer divide, round down); elaboration error if below 2.
- `DATA_BITS`, default 9: word width, legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even. Elaboration error for any other value.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: queue depth, a power of two ≥ 2.
- `clock  in  1`: single clock. All logic is on the rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `send  in  1`: enqueue request. A word is accepted on a rising edge where `send && ready`.
- `data  in  DATA_BITS`: word to enqueue. Transmitted LSB first.
- `ready  out  1`: high when the queue is not full (`count != FIFO_DEPTH`).
- `tx  out  1`: registered serial line. Idles high.
- `busy  out  1`: high when the FSM is not in IDLE, or `count != 0`.
- `count  out  $clog2(FIFO_DEPTH)+1`: number of queued words, excluding the word currently being transmitted.

## Operation
- **Frame layout:** start (0), `DATA_BITS` data bits LSB first, optional parity bit, then `STOP_BITS` stop bits (1). Each bit is held exactly `BIT_CYCLES` clocks.
- **Parity:**
  - Odd: ones in data plus parity is odd.
  - Even: ones in data plus parity is even.
  - Parity is computed from the popped word at pop time.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `count != 0`, pop the head into the shift register and go to START.
  - START → DATA after `BIT_CYCLES`.
  - DATA: after the `DATA_BITS`-th bit period, go to PARITY if `PARITY != 0`, otherwise to STOP.
  - PARITY → STOP after one bit period.
  - STOP lasts `STOP_BITS * BIT_CYCLES`. On its final cycle:
    - if `count != 0`, pop and go directly to START (back-to-back frames, zero idle cycles);
    - otherwise go to IDLE.
- **Counters:**
  - The bit-period counter (`$clog2(BIT_CYCLES)` bits) restarts at 0 on every state entry and on every bit advance.
  - The data-bit counter (4 bits) clears on START entry.
- **Queue:**
  - Circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle: `count` unchanged, both pointers advance.
  - `send` while `ready = 0`: ignored. The word is dropped and no state changes.
  - Pop never occurs when `count = 0`.
- **Reset:** applies mid-frame or at any time.
  - FSM → IDLE, pointers and `count` → 0, queued words discarded, in-flight frame aborted.
  - `tx` is high from the edge that samples `reset`.
  - `send` is ignored while `reset` is high.

## Timing
- **Reset values:** `tx = 1`, `ready = 1`, `busy = 0`, `count = 0`.
- **Start latency:** word accepted at edge k into an empty queue with the FSM in IDLE.
  - `count = 1` after edge k.
  - Pop at edge k+1.
  - `tx` low after edge k+2.
- **Frame length:** `(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BIT_CYCLES` clocks.
- **Back-to-back frames:** the next start bit begins on the clock immediately after the last stop-bit clock.
- **`ready`** is combinational from registered `count`. It may rise in the same cycle a pop frees an entry only after the edge that performs the pop.
- **`busy`** falls on the edge that moves the FSM to IDLE with `count = 0`.

## Test plan
- **Single 8N1 frame:** `CLK_HZ=1000, BAUD_RATE=100, DATA_BITS=8, PARITY=0, STOP_BITS=1`; send `0xA5` from idle.
  - `tx` goes low 2 edges after accept.
  - Then bits `0,1,0,1,0,0,1,0,1,1`, each exactly 10 clocks.
  - `busy` falls after the stop bit.
- **Parity:** `DATA_BITS=8`; send `0xA5` with `PARITY=2`, expect parity bit 0; with `PARITY=1`, expect parity bit 1. Send `0x07` with `PARITY=2`, expect parity bit 1.
- **Two stop bits, 7-bit word:** `DATA_BITS=7, STOP_BITS=2`; send `0x41`.
  - Frame is 10 bits.
  - High stop period is exactly 20 clocks before the next start.
- **Queue full:** `FIFO_DEPTH=4`; from idle, assert `send` for 6 consecutive cycles with words 0..5.
  - Words 0–4 are accepted; word 5 is rejected (`ready = 0`, `count = 4`).
  - Exactly five frames go out back-to-back, with zero idle cycles between stop and start.
- **Wrap-around:** stream 12 words through `FIFO_DEPTH=4`, keeping `count` between 1 and 3. The transmitted order equals the send order.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 3 with 2 words queued.
  - `tx = 1`, `count = 0`, `busy = 0` after the edge.
  - No further frames.
  - A new `send` produces a clean frame.
